// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter for the shared GPIO peripheral bus port.
// Locked ownership with direct handover, owner-only return path and a slave watchdog.
module gpio_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    output logic        m0_grnt,
    input  logic        m0_as_,
    input  logic        m0_rw,
    input  logic [1:0]  m0_addr,
    input  logic [31:0] m0_wr_data,
    output logic [31:0] m0_rd_data,
    output logic        m0_rdy_,
    input  logic        m1_req,
    output logic        m1_grnt,
    input  logic        m1_as_,
    input  logic        m1_rw,
    input  logic [1:0]  m1_addr,
    input  logic [31:0] m1_wr_data,
    output logic [31:0] m1_rd_data,
    output logic        m1_rdy_,
    output logic        s_cs_,
    output logic        s_as_,
    output logic        s_rw,
    output logic [1:0]  s_addr,
    output logic [31:0] s_wr_data,
    input  logic [31:0] s_rd_data,
    input  logic        s_rdy_,
    output logic        timeout,
    output logic        timeout_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic             last_owner_r;
    logic             next_last_owner_s;
    logic             timeout_id_r;
    logic             next_timeout_id_s;
    logic [CNT_W-1:0] wd_cnt_r;
    logic [CNT_W-1:0] next_wd_cnt_s;
    logic             stall_s;
    logic             abort_s;

    assign m0_grnt    = (state_r == OWN0);
    assign m1_grnt    = (state_r == OWN1);
    assign timeout_id = timeout_id_r;

    // The slave has been strobed by the owner and has not answered this cycle.
    assign stall_s = (state_r != IDLE) && !s_as_ && s_rdy_;
    assign abort_s = stall_s && (wd_cnt_r == TO_LAST);
    assign timeout = abort_s && !reset;

    // Owner's bus signals onto the slave port; idle values otherwise.
    always_comb begin
        s_cs_     = 1'b1;
        s_as_     = 1'b1;
        s_rw      = 1'b1;
        s_addr    = 2'd0;
        s_wr_data = 32'd0;
        case (state_r)
            OWN0: begin
                s_cs_     = 1'b0;
                s_as_     = m0_as_;
                s_rw      = m0_rw;
                s_addr    = m0_addr;
                s_wr_data = m0_wr_data;
            end
            OWN1: begin
                s_cs_     = 1'b0;
                s_as_     = m1_as_;
                s_rw      = m1_rw;
                s_addr    = m1_addr;
                s_wr_data = m1_wr_data;
            end
            default: begin
                s_cs_     = 1'b1;
                s_as_     = 1'b1;
                s_rw      = 1'b1;
                s_addr    = 2'd0;
                s_wr_data = 32'd0;
            end
        endcase
    end

    // Slave read data and ready go back to the owner only.
    always_comb begin
        m0_rd_data = 32'd0;
        m0_rdy_    = 1'b1;
        m1_rd_data = 32'd0;
        m1_rdy_    = 1'b1;
        case (state_r)
            OWN0: begin
                m0_rd_data = s_rd_data;
                m0_rdy_    = s_rdy_;
            end
            OWN1: begin
                m1_rd_data = s_rd_data;
                m1_rdy_    = s_rdy_;
            end
            default: begin
                m0_rd_data = 32'd0;
                m0_rdy_    = 1'b1;
                m1_rd_data = 32'd0;
                m1_rdy_    = 1'b1;
            end
        endcase
    end

    // Arbitration, release/handover and watchdog abort decisions.
    always_comb begin
        next_state_s      = state_r;
        next_last_owner_s = last_owner_r;
        next_timeout_id_s = timeout_id_r;
        case (state_r)
            IDLE: begin
                if (m0_req && m1_req) begin
                    next_state_s = last_owner_r ? OWN0 : OWN1;
                end else if (m0_req) begin
                    next_state_s = OWN0;
                end else if (m1_req) begin
                    next_state_s = OWN1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0: begin
                if (abort_s) begin
                    // Abort wins over a simultaneous release or handover.
                    next_state_s      = IDLE;
                    next_last_owner_s = 1'b0;
                    next_timeout_id_s = 1'b0;
                end else if (m0_req) begin
                    next_state_s = OWN0;
                end else begin
                    next_last_owner_s = 1'b0;
                    next_state_s      = m1_req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (abort_s) begin
                    next_state_s      = IDLE;
                    next_last_owner_s = 1'b1;
                    next_timeout_id_s = 1'b1;
                end else if (m1_req) begin
                    next_state_s = OWN1;
                end else begin
                    next_last_owner_s = 1'b1;
                    next_state_s      = m0_req ? OWN0 : IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Watchdog counts only uninterrupted stall cycles within one ownership.
    always_comb begin
        next_wd_cnt_s = '0;
        if (next_state_s != state_r) begin
            next_wd_cnt_s = '0;
        end else if (stall_s) begin
            next_wd_cnt_s = wd_cnt_r + CNT_W'(1);
        end else begin
            next_wd_cnt_s = '0;
        end
    end

    // State, round-robin history, watchdog and abort identity registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            timeout_id_r <= 1'b0;
            wd_cnt_r     <= '0;
        end else begin
            state_r      <= next_state_s;
            last_owner_r <= next_last_owner_s;
            timeout_id_r <= next_timeout_id_s;
            wd_cnt_r     <= next_wd_cnt_s;
        end
    end

    gpio_bus_arbiter_chk u_chk (
        .clk     (clk),
        .reset   (reset),
        .m0_grnt (m0_grnt),
        .m1_grnt (m1_grnt),
        .s_cs_   (s_cs_),
        .timeout (timeout)
    );

endmodule

// Structural invariants of the arbiter: exclusive grants, chip select tied to
// ownership, and an abort always releasing the bus on the following cycle.
module gpio_bus_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic m0_grnt,
    input logic m1_grnt,
    input logic s_cs_,
    input logic timeout
);

    a_grant_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(m0_grnt && m1_grnt));

    a_cs_follows_grant: assert property (@(posedge clk) disable iff (reset)
        s_cs_ == !(m0_grnt || m1_grnt));

    a_timeout_releases: assert property (@(posedge clk) disable iff (reset)
        timeout |=> !(m0_grnt || m1_grnt));

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: directed vector table, hand-built
// watchdog/reset sequences, then random traffic against a behavioural model.
module tb_gpio_bus_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_grnt, m0_as_, m0_rw, m0_rdy_;
    logic [1:0]  m0_addr;
    logic [31:0] m0_wr_data, m0_rd_data;
    logic        m1_req, m1_grnt, m1_as_, m1_rw, m1_rdy_;
    logic [1:0]  m1_addr;
    logic [31:0] m1_wr_data, m1_rd_data;
    logic        s_cs_, s_as_, s_rw, s_rdy_;
    logic [1:0]  s_addr;
    logic [31:0] s_wr_data, s_rd_data;
    logic        timeout, timeout_id;

    int n_total = 0;
    int n_pass  = 0;

    // behavioural model: owner -1 = nobody
    int mdl_owner = -1;
    int mdl_last  = 1;
    int mdl_cnt   = 0;
    int mdl_tid   = 0;

    gpio_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_grnt(m0_grnt), .m0_as_(m0_as_), .m0_rw(m0_rw),
        .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data), .m0_rdy_(m0_rdy_),
        .m1_req(m1_req), .m1_grnt(m1_grnt), .m1_as_(m1_as_), .m1_rw(m1_rw),
        .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data), .m1_rdy_(m1_rdy_),
        .s_cs_(s_cs_), .s_as_(s_as_), .s_rw(s_rw), .s_addr(s_addr),
        .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
        .timeout(timeout), .timeout_id(timeout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, as0, as1, rw0;
        logic [1:0]  a0;
        logic [31:0] wd0, srd;
        logic        srdy;
        logic        e_g0, e_g1, e_cs, e_sas;
        logic [1:0]  e_saddr;
        logic [31:0] e_swd, e_rd0, e_rd1;
        logic        e_rdy0, e_rdy1;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic req_of(int m);
        return (m == 0) ? m0_req : m1_req;
    endfunction

    function automatic logic as_of(int m);
        return (m == 0) ? m0_as_ : m1_as_;
    endfunction

    // Apply the rules at a clock edge using the inputs sampled there.
    task automatic model_update();
        int  prev;
        logic stall;
        if (reset) begin
            mdl_owner = -1; mdl_last = 1; mdl_cnt = 0; mdl_tid = 0;
        end else begin
            prev  = mdl_owner;
            stall = (prev >= 0) && !as_of(prev) && s_rdy_;
            if (stall && mdl_cnt == TO - 1) begin
                mdl_owner = -1; mdl_last = prev; mdl_tid = prev;
            end else if (prev < 0) begin
                if (m0_req && m1_req) mdl_owner = 1 - mdl_last;
                else if (m0_req)      mdl_owner = 0;
                else if (m1_req)      mdl_owner = 1;
            end else if (!req_of(prev)) begin
                mdl_last  = prev;
                mdl_owner = req_of(1 - prev) ? 1 - prev : -1;
            end
            mdl_cnt = (mdl_owner != prev) ? 0 : (stall ? mdl_cnt + 1 : 0);
        end
    endtask

    task automatic model_check(input int cyc);
        int   o;
        logic stall;
        o     = mdl_owner;
        stall = (o >= 0) && !as_of(o) && s_rdy_;
        chk($sformatf("rnd%0d m0_grnt", cyc), 32'(m0_grnt), 32'(o == 0));
        chk($sformatf("rnd%0d m1_grnt", cyc), 32'(m1_grnt), 32'(o == 1));
        chk($sformatf("rnd%0d s_cs_", cyc), 32'(s_cs_), 32'(o < 0));
        chk($sformatf("rnd%0d s_as_", cyc), 32'(s_as_), 32'((o < 0) ? 1'b1 : as_of(o)));
        chk($sformatf("rnd%0d s_rw", cyc), 32'(s_rw),
            32'((o == 0) ? m0_rw : (o == 1) ? m1_rw : 1'b1));
        chk($sformatf("rnd%0d s_addr", cyc), 32'(s_addr),
            32'((o == 0) ? m0_addr : (o == 1) ? m1_addr : 2'd0));
        chk($sformatf("rnd%0d s_wr_data", cyc), s_wr_data,
            (o == 0) ? m0_wr_data : (o == 1) ? m1_wr_data : 32'd0);
        chk($sformatf("rnd%0d m0_rd_data", cyc), m0_rd_data, (o == 0) ? s_rd_data : 32'd0);
        chk($sformatf("rnd%0d m1_rd_data", cyc), m1_rd_data, (o == 1) ? s_rd_data : 32'd0);
        chk($sformatf("rnd%0d m0_rdy_", cyc), 32'(m0_rdy_), 32'((o == 0) ? s_rdy_ : 1'b1));
        chk($sformatf("rnd%0d m1_rdy_", cyc), 32'(m1_rdy_), 32'((o == 1) ? s_rdy_ : 1'b1));
        chk($sformatf("rnd%0d timeout", cyc), 32'(timeout),
            32'(!reset && stall && (mdl_cnt == TO - 1)));
        chk($sformatf("rnd%0d timeout_id", cyc), 32'(timeout_id), 32'(mdl_tid));
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_grants(input string nm, input logic g0, input logic g1);
        chk({nm, " m0_grnt"}, 32'(m0_grnt), 32'(g0));
        chk({nm, " m1_grnt"}, 32'(m1_grnt), 32'(g1));
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_as_ = 1'b1; m0_rw = 1'b1; m0_addr = 2'd0; m0_wr_data = 32'd0;
        m1_req = 1'b0; m1_as_ = 1'b1; m1_rw = 1'b1; m1_addr = 2'd3; m1_wr_data = 32'h1111_1111;
        s_rd_data = 32'd0; s_rdy_ = 1'b1;

        //         r0    r1    as0   as1   rw0   a0    wd0            srd            srdy    g0    g1    cs    sas   saddr swd            rd0            rd1            rdy0  rdy1
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1,   1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_1234, 1'b1,   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_1234, 32'h0,         1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_1234, 1'b0,   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_1234, 32'h0,         1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_1234, 1'b1,   1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_A5A5, 32'h0000_1234, 32'h0,         1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_5555, 1'b1,   1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h1111_1111, 32'h0,         32'h0000_5555, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_5555, 1'b0,   1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h1111_1111, 32'h0,         32'h0000_5555, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_A5A5, 32'h0000_5555, 1'b1,   1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h1111_1111, 32'h0,         32'h0000_5555, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_00C3, 32'h0,         1'b1,   1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_00C3, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_00C3, 32'h0,         1'b1,   1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_00C3, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,         32'h0,         1'b1,   1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h1111_1111, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1,   1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0,         32'h0000_FFFF, 1'b0,   1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0,         32'h0000_FFFF, 32'h0,         1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0,         32'h0000_FFFF, 1'b1,   1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_FFFF, 32'h0,         1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1,   1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1,   1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'h1111_1111, 32'h0,         32'h0,         1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         1'b1,   1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1};

        // reset held for three cycles
        edge_step(); edge_step(); edge_step();
        @(negedge clk);
        chk_grants("reset", 1'b0, 1'b0);
        chk("reset s_cs_", 32'(s_cs_), 32'd1);
        chk("reset s_as_", 32'(s_as_), 32'd1);
        chk("reset m0_rdy_", 32'(m0_rdy_), 32'd1);
        chk("reset m1_rdy_", 32'(m1_rdy_), 32'd1);
        chk("reset timeout", 32'(timeout), 32'd0);
        chk("reset timeout_id", 32'(timeout_id), 32'd0);
        edge_step();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            m0_req = vecs[i].r0; m1_req = vecs[i].r1;
            m0_as_ = vecs[i].as0; m1_as_ = vecs[i].as1;
            m0_rw = vecs[i].rw0; m0_addr = vecs[i].a0; m0_wr_data = vecs[i].wd0;
            s_rd_data = vecs[i].srd; s_rdy_ = vecs[i].srdy;
            @(negedge clk);
            chk_grants($sformatf("row%0d", i), vecs[i].e_g0, vecs[i].e_g1);
            chk($sformatf("row%0d s_cs_", i), 32'(s_cs_), 32'(vecs[i].e_cs));
            chk($sformatf("row%0d s_as_", i), 32'(s_as_), 32'(vecs[i].e_sas));
            chk($sformatf("row%0d s_addr", i), 32'(s_addr), 32'(vecs[i].e_saddr));
            chk($sformatf("row%0d s_wr_data", i), s_wr_data, vecs[i].e_swd);
            chk($sformatf("row%0d m0_rd_data", i), m0_rd_data, vecs[i].e_rd0);
            chk($sformatf("row%0d m1_rd_data", i), m1_rd_data, vecs[i].e_rd1);
            chk($sformatf("row%0d m0_rdy_", i), 32'(m0_rdy_), 32'(vecs[i].e_rdy0));
            chk($sformatf("row%0d m1_rdy_", i), 32'(m1_rdy_), 32'(vecs[i].e_rdy1));
            chk($sformatf("row%0d timeout", i), 32'(timeout), 32'd0);
            edge_step();
        end

        // m1 watchdog: slave never answers
        m0_req = 1'b0; m1_req = 1'b1; m0_as_ = 1'b1; m1_as_ = 1'b1; s_rdy_ = 1'b1;
        @(negedge clk);
        chk_grants("wd1 pre", 1'b0, 1'b0);
        edge_step();
        m1_as_ = 1'b0; m0_as_ = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk_grants($sformatf("wd1 c%0d", k), 1'b0, 1'b1);
            chk($sformatf("wd1 c%0d timeout", k), 32'(timeout), 32'(k == 16));
            chk($sformatf("wd1 c%0d s_as_", k), 32'(s_as_), 32'd0);
            edge_step();
        end
        @(negedge clk);
        chk_grants("wd1 post", 1'b0, 1'b0);
        chk("wd1 post timeout", 32'(timeout), 32'd0);
        chk("wd1 post timeout_id", 32'(timeout_id), 32'd1);
        chk("wd1 post s_as_", 32'(s_as_), 32'd1);
        edge_step();
        m1_req = 1'b0; m1_as_ = 1'b1;
        @(negedge clk);
        chk_grants("wd1 rearb", 1'b0, 1'b1);
        edge_step();

        // m0 watchdog coinciding with req drop while m1 waits
        m0_req = 1'b1; m1_req = 1'b1; m0_as_ = 1'b0; m1_as_ = 1'b1; s_rdy_ = 1'b1;
        @(negedge clk);
        chk_grants("wd0 pre", 1'b0, 1'b0);
        edge_step();
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) m0_req = 1'b0;
            @(negedge clk);
            chk_grants($sformatf("wd0 c%0d", k), 1'b1, 1'b0);
            chk($sformatf("wd0 c%0d timeout", k), 32'(timeout), 32'(k == 16));
            edge_step();
        end
        @(negedge clk);
        chk_grants("wd0 post", 1'b0, 1'b0);
        chk("wd0 post timeout_id", 32'(timeout_id), 32'd0);
        edge_step();
        @(negedge clk);
        chk_grants("wd0 rearb", 1'b0, 1'b1);
        m1_req = 1'b0; m0_req = 1'b1;
        edge_step();

        // reset during a granted read
        s_rdy_ = 1'b0; s_rd_data = 32'h0000_DEAD;
        @(negedge clk);
        chk_grants("rst read", 1'b1, 1'b0);
        chk("rst read m0_rd_data", m0_rd_data, 32'h0000_DEAD);
        edge_step();
        reset = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        chk_grants("rst edge", 1'b1, 1'b0);
        edge_step();
        reset = 1'b0;
        @(negedge clk);
        chk_grants("rst after", 1'b0, 1'b0);
        chk("rst after s_cs_", 32'(s_cs_), 32'd1);
        chk("rst after s_as_", 32'(s_as_), 32'd1);
        chk("rst after m0_rd_data", m0_rd_data, 32'd0);
        chk("rst after m0_rdy_", 32'(m0_rdy_), 32'd1);
        edge_step();
        @(negedge clk);
        chk_grants("rst first arb", 1'b1, 1'b0);
        edge_step();

        // random traffic against the model
        reset = 1'b1;
        edge_step(); edge_step();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (((c / 100) % 2) == 1) begin
                s_rdy_ = 1'b1;
                if ($urandom_range(39) == 0) m0_as_ = ~m0_as_;
                if ($urandom_range(39) == 0) m1_as_ = ~m1_as_;
                if ($urandom_range(31) == 0) m0_req = ~m0_req;
                if ($urandom_range(31) == 0) m1_req = ~m1_req;
            end else begin
                s_rdy_ = ($urandom_range(5) == 0) ? 1'b0 : 1'b1;
                if ($urandom_range(5) == 0) m0_as_ = ~m0_as_;
                if ($urandom_range(5) == 0) m1_as_ = ~m1_as_;
                if ($urandom_range(7) == 0) m0_req = ~m0_req;
                if ($urandom_range(7) == 0) m1_req = ~m1_req;
            end
            reset      = ($urandom_range(299) == 0) ? 1'b1 : 1'b0;
            m0_rw      = 1'($urandom_range(1));
            m1_rw      = 1'($urandom_range(1));
            m0_addr    = 2'($urandom_range(3));
            m1_addr    = 2'($urandom_range(3));
            m0_wr_data = $urandom;
            m1_wr_data = $urandom;
            s_rd_data  = $urandom;
            @(negedge clk);
            model_check(c);
            edge_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
